// File: rtl/times_table_mem_if.sv
// Request/response bundle for the times-table lookup: operands and control in,
// table status and product strobes out.
interface times_table_mem_if #(
    parameter int W = 3
);
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           read;
    logic           reinit;
    logic           ready;
    logic [2*W-1:0] result;
    logic           result_valid;
    logic           rd_err;

    modport master (
        output a, b, read, reinit,
        input  ready, result, result_valid, rd_err
    );

    modport slave (
        input  a, b, read, reinit,
        output ready, result, result_valid, rd_err
    );
endinterface

// File: rtl/times_table_mem.sv
// RAM-backed unsigned multiplier lookup: a fill engine writes a*b for every
// operand pair after reset or reinit, then reads return the product with fixed latency.
module times_table_mem_chk (
    input logic clk,
    input logic rst_n,
    input logic ready,
    input logic in_ready_state,
    input logic cnt_zero
);
    a_ready_tracks_state: assert property (@(posedge clk) disable iff (!rst_n)
        ready == in_ready_state);
    a_cnt_idle_in_ready: assert property (@(posedge clk) disable iff (!rst_n)
        in_ready_state |-> cnt_zero);
endmodule

module times_table_mem #(
    parameter int W       = 3,
    parameter bit OUT_REG = 1'b0
) (
    input logic               clk,
    input logic               rst_n,
    times_table_mem_if.slave  bus
);
    localparam int AW    = 2 * W;
    localparam int DEPTH = 1 << AW;

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic            ready_q, ready_d;
    logic [AW-1:0]   mem_q [DEPTH];
    logic [AW-1:0]   rd_addr_s;
    logic            wr_en_s;
    logic            accept_s;
    logic            drop_s;
    logic [AW-1:0]   res1_q;
    logic            vld1_q;
    logic            err_q;

    // Table entry for a fill address {a,b}: product of its upper and lower halves.
    function automatic logic [AW-1:0] product(input logic [AW-1:0] addr);
        logic [AW-1:0] hi;
        logic [AW-1:0] lo;
        hi = {{W{1'b0}}, addr[AW-1:W]};
        lo = {{W{1'b0}}, addr[W-1:0]};
        return hi * lo;
    endfunction

    assign rd_addr_s = {bus.a, bus.b};

    // Next-state logic for the fill engine and read acceptance.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ready_d  = ready_q;
        wr_en_s  = 1'b0;
        accept_s = 1'b0;
        drop_s   = 1'b0;
        case (state_q)
            ST_INIT: begin
                wr_en_s = 1'b1;
                drop_s  = bus.read;
                if (cnt_q == {AW{1'b1}}) begin
                    state_d = ST_READY;
                    cnt_d   = '0;
                    ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + {{(AW-1){1'b0}}, 1'b1};
                end
            end
            ST_READY: begin
                // A read on the reinit edge still sees the old, identical table.
                accept_s = bus.read;
                if (bus.reinit) begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                    ready_d = 1'b0;
                end else begin
                    state_d = ST_READY;
                end
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = '0;
                ready_d = 1'b0;
                drop_s  = bus.read;
            end
        endcase
    end

    // Fill engine state, counter and ready flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

    // Table storage; contents are don't-care until the fill completes.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[cnt_q] <= product(cnt_q);
        end
    end

    // First read stage: synchronous table read plus drop strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res1_q <= '0;
            vld1_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            vld1_q <= accept_s;
            err_q  <= drop_s;
            if (accept_s) begin
                res1_q <= mem_q[rd_addr_s];
            end
        end
    end

    generate
        if (OUT_REG) begin : g_out_reg
            logic [AW-1:0] res2_q;
            logic          vld2_q;

            // Optional output stage; result only moves when a product arrives.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    res2_q <= '0;
                    vld2_q <= 1'b0;
                end else begin
                    vld2_q <= vld1_q;
                    if (vld1_q) begin
                        res2_q <= res1_q;
                    end
                end
            end

            assign bus.result       = res2_q;
            assign bus.result_valid = vld2_q;
        end else begin : g_out_direct
            assign bus.result       = res1_q;
            assign bus.result_valid = vld1_q;
        end
    endgenerate

    assign bus.ready  = ready_q;
    assign bus.rd_err = err_q;

    times_table_mem_chk u_chk (
        .clk            (clk),
        .rst_n          (rst_n),
        .ready          (ready_q),
        .in_ready_state (state_q == ST_READY),
        .cnt_zero       (cnt_q == '0)
    );
endmodule
